uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//  - Byte-to-serial UART transmitter: 8N1 (or 8E1 / 8N2), LSB first. Sits directly downstream of the frame builder.
//  - Consumes the frame builder's tx_en strobe and data byte.
//  - Returns tx_rdy; the frame builder steps to its next byte on the rising edge of tx_rdy.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD_RATE  115200      line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (truncated, must be >= 2)
//  STOP_BITS  1           number of stop bits, 1 or 2
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rstn      in   1  reset, asynchronous, active-low
//  tx_en     in   1  one-cycle request to send tx_data
//  tx_data   in   8  byte to send; sampled only in the accept cycle
//  tx_rdy    out  1  1 = idle and able to accept; 0 = frame in progress
//  tx        out  1  serial line, idles high
//  overrun   out  1  one-cycle pulse: tx_en arrived while tx_rdy=0
//  frame_cnt out  16 frames completed since reset, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (rstn=0, effective immediately): tx=1, tx_rdy=1, overrun=0, frame_cnt=0, FSM=IDLE, counters cleared.
//  - Reset mid-frame: line returns high at once; the partial byte is discarded and not counted.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1, tx_rdy=1.
//    - On tx_en=1: latch tx_data into the shift register, go to START.
//  - Accept latency: tx_en high at edge N -> at edge N+1 tx=0 and tx_rdy=0.
//  - Every bit is held for exactly CLKS_PER_BIT cycles.
//    - Baud counter runs 0..CLKS_PER_BIT-1 and restarts on every state change.
//  - START: tx=0 for one bit time.
//  - DATA: bit index 0..7, tx=shift[0], shift right once per bit time; LSB first.
//  - STOP: tx=1 for STOP_BITS bit times.
//  - End of frame: on the last cycle of the last stop bit, go to IDLE, set tx_rdy=1, frame_cnt+=1.
//  - Frame length, accept edge to tx_rdy rise: (10 + STOP_BITS - 1 + PARITY) * CLKS_PER_BIT cycles.
//  - tx_en while tx_rdy=0, including the final stop cycle: ignored, overrun=1 for the next cycle; frame unaffected.
//  - tx_data changes after the accept cycle: no effect on the frame in flight.
//  - tx and tx_rdy are registered outputs (no combinational path from inputs).
//  - Back-to-back: tx_en in the first cycle with tx_rdy=1 is accepted. The start bit follows the previous stop bit with no extra idle.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - PARITY state inserted after DATA; tx = XOR of the 8 latched data bits (even parity), one bit time.
//    - PARITY term in the frame length = 1.
//  UART_TX_PARITY_EN undefined:
//    - No PARITY state; DATA goes straight to STOP.
//    - PARITY term in the frame length = 0.
// TESTING (bench: CLK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10)
//  1. Reset release, no tx_en for 200 cycles -> tx=1, tx_rdy=1, overrun=0, frame_cnt=0.
//  2. tx_en with 0x66, STOP_BITS=1, no parity
//     -> line samples at bit centres: 0,0,1,1,0,0,1,1,0,1.
//     -> tx_rdy low for 100 cycles, then rises; frame_cnt=1.
//  3. UART_TX_PARITY_EN, send 0x61 then 0x66
//     -> parity bits 1 then 0; each frame 110 cycles.
//  4. tx_en at cycle 40 of a frame, tx_data=0xFF
//     -> overrun pulses one cycle; serial output still matches the original byte; frame_cnt +1 only.
//  5. Frame-builder loop: 46 bytes, each accepted via tx_en ~100 cycles after the tx_rdy rise
//     -> byte order preserved, no overrun, frame_cnt=46.
//  6. rstn low at cycle 35 of a frame sending 0x5A
//     -> tx=1 and tx_rdy=1 immediately; frame_cnt unchanged; next tx_en sends a full clean frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter, 8 data bits, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state    | meaning
// S_IDLE   | line high, ready to accept a byte
// S_START  | start bit (line low)
// S_DATA   | eight data bits, shift[0] on the line
// S_PARITY | even parity of the latched byte (parity build only)
// S_STOP   | STOP_BITS stop bits (line high)
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_en,
  input  logic [7:0]  tx_data,
  output logic        tx_rdy,
  output logic        tx,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d is the value the line takes after the coming edge, so every
  // transition also sets up the first bit of the state it enters.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    ovr_d   = tx_en & ~rdy_q;
    cnt_d   = cnt_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        rdy_d  = 1'b1;
        if (tx_en) begin
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          state_d = S_START;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
            tx_d    = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign tx_rdy    = rdy_q;
  assign overrun   = ovr_q;
  assign frame_cnt = cnt_q;

endmodule
